// File: rtl/slib_input_filter_mc_if.sv
// Signal bundle for the multi-channel input filter: the sample enable,
// the bypass control, raw inputs and the filtered outputs with edge pulses.
interface slib_input_filter_mc_if #(
    parameter int WIDTH = 8
);
    logic             CE;
    logic             BYPASS;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    // Side that drives raw inputs and consumes the filtered levels
    modport master (
        output CE,
        output BYPASS,
        output D,
        input  Q,
        input  RISE,
        input  FALL
    );

    // The filter itself
    modport slave (
        input  CE,
        input  BYPASS,
        input  D,
        output Q,
        output RISE,
        output FALL
    );
endinterface

// File: rtl/slib_input_filter_mc.sv
// Multi-channel integrating input filter with hysteresis.
// Each channel keeps a saturating up/down counter that follows its raw input
// on enabled samples; the filtered level sets when the counter reaches the
// high threshold and clears when it falls to the low threshold. A bypass
// mode copies the inputs straight through and parks the counters at the
// matching rail so that leaving bypass is glitch-free.
module slib_input_filter_mc #(
    parameter int WIDTH  = 8,
    parameter int SIZE   = 4,
    parameter int THR_HI = SIZE,
    parameter int THR_LO = 0,
    parameter bit INIT   = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    slib_input_filter_mc_if.slave bus
);

    localparam int CW = $clog2(SIZE + 1);

    localparam logic [CW-1:0] FULL = CW'(SIZE);
    localparam logic [CW-1:0] HI_C = CW'(THR_HI);
    localparam logic [CW-1:0] LO_C = CW'(THR_LO);
    localparam logic [CW-1:0] RST_CNT = INIT ? FULL : '0;

    // Refuse to build with thresholds that would make the hysteresis band
    // empty or unreachable.
    if (WIDTH < 1 || SIZE < 1 || THR_LO < 0 || THR_LO >= THR_HI || THR_HI > SIZE) begin : g_bad_param
        $error("slib_input_filter_mc: need WIDTH>=1, SIZE>=1, 0<=THR_LO<THR_HI<=SIZE");
    end

    // Saturating integrator step: count toward the input level, stop at rails.
    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c, input logic up);
        logic [CW-1:0] r;
        r = c;
        if (up) begin
            if (c != FULL) r = c + CW'(1);
        end else begin
            if (c != '0) r = c - CW'(1);
        end
        return r;
    endfunction

    // Hysteresis decision from the count before the edge.
    function automatic logic hyst(input logic [CW-1:0] c, input logic q_now);
        logic r;
        r = q_now;
        if (c >= HI_C)      r = 1'b1;
        else if (c <= LO_C) r = 1'b0;
        return r;
    endfunction

    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;

    // Next count and next level per channel; bypass overrides both.
    always_comb begin
        q_nxt = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (bus.BYPASS) begin
                q_nxt[i]   = bus.D[i];
                cnt_nxt[i] = bus.D[i] ? FULL : '0;
            end else begin
                q_nxt[i] = hyst(cnt[i], q_r[i]);
                if (bus.CE) cnt_nxt[i] = sat_step(cnt[i], bus.D[i]);
            end
        end
    end

    // Integrators, filtered levels and one-cycle edge pulses.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= RST_CNT;
            q_r    <= {WIDTH{INIT}};
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
            q_r    <= q_nxt;
            rise_r <= q_nxt & ~q_r;
            fall_r <= ~q_nxt & q_r;
        end
    end

    assign bus.Q    = q_r;
    assign bus.RISE = rise_r;
    assign bus.FALL = fall_r;

endmodule

// File: tb/tb_slib_input_filter_mc.sv
// Directed bench for slib_input_filter_mc. Three instances cover the default
// thresholds, a narrow hysteresis band (THR_HI=3, THR_LO=1) and INIT=1.
// The driver pushes the expected outputs for each edge into a scoreboard;
// a monitor pops and compares after every edge or on an asynchronous check.
`timescale 1ns/1ps
module tb_slib_input_filter_mc;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rstn_a, rstn_b, rstn_c;

    slib_input_filter_mc_if #(.WIDTH(4)) ifa ();
    slib_input_filter_mc_if #(.WIDTH(4)) ifb ();
    slib_input_filter_mc_if #(.WIDTH(4)) ifc ();

    slib_input_filter_mc #(.WIDTH(4), .SIZE(4), .THR_HI(4), .THR_LO(0), .INIT(1'b0)) dut_a (
        .CLK (CLK), .RSTN(rstn_a), .bus(ifa)
    );
    slib_input_filter_mc #(.WIDTH(4), .SIZE(4), .THR_HI(3), .THR_LO(1), .INIT(1'b0)) dut_b (
        .CLK (CLK), .RSTN(rstn_b), .bus(ifb)
    );
    slib_input_filter_mc #(.WIDTH(4), .SIZE(4), .THR_HI(4), .THR_LO(0), .INIT(1'b1)) dut_c (
        .CLK (CLK), .RSTN(rstn_c), .bus(ifc)
    );

    typedef struct {
        int         sel;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event async_ev;

    exp_t       e;
    logic [3:0] aq, ar, af;

    // Monitor: one comparison per edge (or async strobe) while entries wait.
    initial begin
        forever begin
            @(posedge CLK or async_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0: begin aq = ifa.Q; ar = ifa.RISE; af = ifa.FALL; end
                    1: begin aq = ifb.Q; ar = ifb.RISE; af = ifb.FALL; end
                    default: begin aq = ifc.Q; ar = ifc.RISE; af = ifc.FALL; end
                endcase
                n_tests++;
                if (aq !== e.q || ar !== e.rise || af !== e.fall) begin
                    n_fail++;
                    $display("FAIL %s: got Q=%b RISE=%b FALL=%b, expected Q=%b RISE=%b FALL=%b",
                             e.name, aq, ar, af, e.q, e.rise, e.fall);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic drive(input int sel, input logic ce, input logic byp, input logic [3:0] d);
        case (sel)
            0: begin ifa.CE = ce; ifa.BYPASS = byp; ifa.D = d; end
            1: begin ifb.CE = ce; ifb.BYPASS = byp; ifb.D = d; end
            default: begin ifc.CE = ce; ifc.BYPASS = byp; ifc.D = d; end
        endcase
    endtask

    // Called at a falling edge: apply inputs, expect outputs after next rising edge.
    task automatic step(input int sel, input logic ce, input logic byp, input logic [3:0] d,
                        input logic [3:0] eq, input logic [3:0] er, input logic [3:0] ef,
                        input string name);
        drive(sel, ce, byp, d);
        sb.push_back('{sel: sel, q: eq, rise: er, fall: ef, name: name});
        @(negedge CLK);
    endtask

    // Check outputs between edges (after an asynchronous reset change).
    task automatic async_chk(input int sel, input logic [3:0] eq, input logic [3:0] er,
                             input logic [3:0] ef, input string name);
        #1;
        sb.push_back('{sel: sel, q: eq, rise: er, fall: ef, name: name});
        -> async_ev;
        @(negedge CLK);
    endtask

    bit b_d [17] = '{1,1,0,1,0,1,1,1,0,0,1,0,1,0,0,0,0};
    bit b_q [17] = '{0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,0,0};

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        drive(0, 1'b0, 1'b0, 4'b0000);
        drive(1, 1'b0, 1'b0, 4'b0000);
        drive(2, 1'b0, 1'b0, 4'b0000);
        @(negedge CLK);

        // Reset values
        async_chk(0, 4'b0000, 4'b0000, 4'b0000, "a_reset");
        async_chk(1, 4'b0000, 4'b0000, 4'b0000, "b_reset");
        async_chk(2, 4'b1111, 4'b0000, 4'b0000, "c_reset_init1");

        // Ramp channel 0: Q rises on the 5th functional edge
        rstn_a = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "a_ramp");
        step(0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "a_rise");
        step(0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "a_rise_once");
        step(0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "a_hold_hi");

        // Single-cycle low glitches every third cycle at the upper rail
        for (int k = 0; k < 6; k++)
            step(0, 1'b1, 1'b0, (k % 3 == 0) ? 4'b0000 : 4'b0001,
                 4'b0001, 4'b0000, 4'b0000, "a_glitch_reject");

        // Full decay: Q clears once the count has reached zero
        for (int k = 0; k < 4; k++) step(0, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "a_decay");
        step(0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "a_fall");
        step(0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "a_fall_once");

        // Bypass passes D through with pulses; leaving bypass causes no glitch
        step(0, 1'b1, 1'b1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, "a_byp_on");
        for (int k = 0; k < 3; k++) step(0, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, "a_byp_off");
        step(0, 1'b1, 1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b1010, "a_byp_swap");
        step(0, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, "a_byp_hold_ce0");

        // Asynchronous reset clears Q without a clock edge
        rstn_a = 1'b0;
        async_chk(0, 4'b0000, 4'b0000, 4'b0000, "a_async_rst");

        // CE one-in-four: counts on edges 1,5,9,13, Q rises on edge 14
        rstn_a = 1'b1;
        for (int k = 0; k < 13; k++)
            step(0, (k % 4 == 0), 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "a_ce_slow");
        step(0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, "a_ce_slow_rise");
        for (int k = 0; k < 12; k++)
            step(0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, "a_saturate");

        // Narrow hysteresis band on instance B
        rstn_b = 1'b1;
        for (int k = 0; k < 17; k++)
            step(1, 1'b1, 1'b0, {3'b000, b_d[k]}, {3'b000, b_q[k]},
                 (k == 7) ? 4'b0001 : 4'b0000, (k == 15) ? 4'b0001 : 4'b0000, "b_hyst");

        // INIT=1: starts high, decays, then async reset mid-ramp restores full count
        rstn_c = 1'b1;
        for (int k = 0; k < 2; k++) step(2, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, "c_start_hi");
        for (int k = 0; k < 4; k++) step(2, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, "c_decay");
        step(2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, "c_fall");
        step(2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "c_fall_once");
        for (int k = 0; k < 2; k++) step(2, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "c_ramp");
        #2;
        rstn_c = 1'b0;
        async_chk(2, 4'b1111, 4'b0000, 4'b0000, "c_async_rst");
        rstn_c = 1'b1;
        for (int k = 0; k < 2; k++) step(2, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, "c_release");
        for (int k = 0; k < 4; k++) step(2, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, "c_cnt_full");

        repeat (2) @(negedge CLK);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slib_input_filter_mc.md
SLIB_INPUT_FILTER_MC -- requirements
Module: slib_input_filter_mc

Interface
REQ-001 Parameter WIDTH, default 8: number of independent filter channels, >= 1.
REQ-002 Parameter SIZE, default 4: integrator full-scale count per channel, >= 1.
REQ-003 Parameter THR_HI, default SIZE: count at or above which Q sets.
REQ-004 Parameter THR_LO, default 0: count at or below which Q clears; 0 <= THR_LO < THR_HI <= SIZE is required, else elaboration fails.
REQ-005 Parameter INIT, default 0: per-design reset level of all Q bits (0 or 1).
REQ-006 CLK  input  1  rising-edge clock; single clock domain.
REQ-007 RSTN  input  1  asynchronous active-low reset.
REQ-008 CE  input  1  sample enable; integrators advance only when high.
REQ-009 BYPASS  input  1  synchronous filter bypass, all channels.
REQ-010 D  input  WIDTH  raw inputs, already synchronised to CLK.
REQ-011 Q  output  WIDTH  filtered levels, registered.
REQ-012 RISE  output  WIDTH  one-cycle pulse, Q bit went 0->1.
REQ-013 FALL  output  WIDTH  one-cycle pulse, Q bit went 1->0.

Function
REQ-014 Each channel shall hold an unsigned integrator cnt[i] of $clog2(SIZE+1) bits, range 0..SIZE.
REQ-015 On a CLK edge with CE=1, BYPASS=0: D[i]=1 and cnt[i]!=SIZE -> cnt[i]+1; D[i]=0 and cnt[i]!=0 -> cnt[i]-1; otherwise hold (saturate, no wrap).
REQ-016 With CE=0 and BYPASS=0, cnt[i] shall hold.
REQ-017 Every CLK edge (independent of CE), BYPASS=0: Q[i] <= 1 if pre-edge cnt[i] >= THR_HI; Q[i] <= 0 if pre-edge cnt[i] <= THR_LO; else hold (hysteresis).
REQ-018 Latency consequence: from cnt=0, Q=0, D held 1, CE=1 every cycle, THR_HI=SIZE -> cnt reaches SIZE after edge SIZE, Q rises on edge SIZE+1.
REQ-019 BYPASS=1 at an edge: Q[i] <= D[i]; cnt[i] <= SIZE if D[i]=1 else 0, regardless of CE, so deasserting BYPASS causes no Q glitch.
REQ-020 RISE[i] shall be registered high for exactly the cycle in which Q[i] first reads 1 after reading 0; FALL[i] likewise for 1->0; never both high in one channel.
REQ-021 RISE/FALL shall also fire on Q changes caused by BYPASS.
REQ-022 Channels shall be fully independent; no cross-channel interaction.
REQ-023 A single-cycle D glitch shall never change Q when THR_HI-THR_LO >= 2 and integrator is at a rail.

Reset
REQ-024 RSTN=0 shall immediately force Q to {WIDTH{INIT}}, RISE=0, FALL=0, cnt[i] to SIZE if INIT=1 else 0.
REQ-025 Reset asserted mid-integration shall discard count state; no RISE/FALL pulse on reset or on release.
REQ-026 First functional edge is the first rising CLK with RSTN sampled high.

Verification (WIDTH=4, SIZE=4, THR_HI=4, THR_LO=0, INIT=0 unless stated)
REQ-027 Reset, then D=4'b0001, CE=1 constant -> Q[0] rises on 5th edge, RISE=4'b0001 for that one cycle only; Q[3:1]=0, no pulses.
REQ-028 Q[0]=1 steady, D[0] pulses low 1 cycle every 3 cycles, CE=1 -> cnt[0] oscillates 3..4, Q[0] stays 1, no FALL.
REQ-029 THR_HI=3, THR_LO=1: ramp cnt to 2 from 0 then hold D=0/1 alternating -> Q unchanged (hysteresis); cnt to 3 -> Q=1 next edge; down to 1 -> Q=0 next edge with FALL pulse.
REQ-030 CE toggling 1-in-4 with D=1 -> Q rises 13-16 edges after reset release, cnt never exceeds 4, never wraps after long hold.
REQ-031 BYPASS=1, D=4'b1010 -> Q=4'b1010 next edge, RISE=4'b1010 that cycle; drop BYPASS with D unchanged -> Q stays 1010, no pulses.
REQ-032 INIT=1: RSTN asserted mid-ramp asynchronously -> Q=4'b1111 without a clock edge, RISE/FALL=0; release with D=1 -> no pulses.
